// File: rtl/cntr8_pkg.sv
// Shared state encoding and width constant for the cntr8 command sequencer.
package cntr8_pkg;

  localparam int CNTR_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    STEP = 2'd2,
    DONE = 2'd3
  } seq_state_t;

endpackage

// File: rtl/cntr8_seq_tmr.sv
// STEP-phase watchdog: counts enabled cycles and flags expiry on the TIMEOUT_CYC-th one.
// Instantiated by cntr8_seq only when CNTR8_SEQ_TIMEOUT_EN is defined.
module cntr8_seq_tmr #(
  parameter int unsigned TIMEOUT_CYC = 300
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT_CYC + 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !expired) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = en && (cnt == W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/cntr8_seq.sv
// Sequencer that moves the cntr8 counter to a requested value by load or by stepping,
// parking it between requests. Optional STEP watchdog: define CNTR8_SEQ_TIMEOUT_EN.
import cntr8_pkg::*;

module cntr8_seq #(
  parameter int unsigned TIMEOUT_CYC = 300
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req,
  input  logic [CNTR_W-1:0] target,
  input  logic              step_mode,
  output logic              ack,
  output logic              busy,
  output logic              err,
  output logic              inc,
  output logic              load,
  output logic [CNTR_W-1:0] d_in,
  input  logic [CNTR_W-1:0] d_out
);

  seq_state_t        state_q, state_d;
  logic [CNTR_W-1:0] tgt_q;
  logic              accept;
  logic              match;
  logic              timeout_hit;

  assign match = (d_out == tgt_q);

`ifdef CNTR8_SEQ_TIMEOUT_EN
  logic err_q;

  cntr8_seq_tmr #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_tmr (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (accept),
    .en      (state_q == STEP),
    .expired (timeout_hit)
  );

  // err survives the DONE/IDLE park and is only cleared by the next accepted request
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_q <= 1'b0;
    end else if (accept) begin
      err_q <= 1'b0;
    end else if (state_q == STEP && timeout_hit && !match) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign timeout_hit = 1'b0;
  assign err         = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      tgt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        tgt_q <= target;
      end
    end
  end

  // Counter has no hold state, so every state except STEP defaults to a park reload of d_out
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    ack     = 1'b0;
    load    = 1'b1;
    inc     = 1'b0;
    d_in    = d_out;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          accept  = 1'b1;
          state_d = (!step_mode || d_out == target) ? LOAD : STEP;
        end
      end
      LOAD: begin
        d_in    = tgt_q;
        state_d = DONE;
      end
      STEP: begin
        d_in = tgt_q;
        inc  = (tgt_q > d_out);
        load = match;
        if (match) begin
          state_d = DONE;
        end else if (timeout_hit) begin
          load    = 1'b1;
          d_in    = d_out;
          state_d = DONE;
        end
      end
      DONE: begin
        ack     = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q == LOAD) || (state_q == STEP);

endmodule

// File: tb/tb_cntr8_seq.sv
// Directed bench for cntr8_seq with a behavioural cntr8 model; timeout scenario under CNTR8_SEQ_TIMEOUT_EN.
module tb_cntr8_seq;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       req = 1'b0;
  logic [7:0] target = 8'h00;
  logic       step_mode = 1'b0;
  logic       ack, busy, err, inc, load;
  logic [7:0] d_in;
  logic [7:0] d_out = 8'h00;
  logic       stuck = 1'b0;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  // Counter model: no reset, so a sequencer reset leaves the value where it was
  always @(posedge clk) begin
    if (load)        d_out <= d_in;
    else if (!stuck) d_out <= inc ? d_out + 8'd1 : d_out - 8'd1;
  end

  cntr8_seq #(.TIMEOUT_CYC(8)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (req),
    .target    (target),
    .step_mode (step_mode),
    .ack       (ack),
    .busy      (busy),
    .err       (err),
    .inc       (inc),
    .load      (load),
    .d_in      (d_in),
    .d_out     (d_out)
  );

  task automatic test_reset();
    int bad;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    compared++;
    if (load !== 1'b1 || d_in !== 8'h00 || busy !== 1'b0 || ack !== 1'b0 || err !== 1'b0 || inc !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_outputs: load=%b d_in=%h busy=%b ack=%b err=%b inc=%b, want 1 00 0 0 0 0",
               load, d_in, busy, ack, err, inc);
    end
    reset_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (d_out !== 8'h00 || busy !== 1'b0) bad++;
    end
    compared++;
    if (bad != 0) begin
      mismatched++;
      $display("[TB] FAIL reset_park: %0d cycles off, d_out=%h busy=%b, want 00 0", bad, d_out, busy);
    end
  endtask

  task automatic test_load();
    int k;
    req = 1'b1; target = 8'h10; step_mode = 1'b0;
    @(posedge clk);
    for (k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) begin
        compared++;
        if (load !== 1'b1 || d_in !== 8'h10 || busy !== 1'b1) begin
          mismatched++;
          $display("[TB] FAIL load_cycle: load=%b d_in=%h busy=%b, want 1 10 1", load, d_in, busy);
        end
      end
      if (ack === 1'b1) break;
    end
    req = 1'b0;
    compared++;
    if (k != 2 || d_out !== 8'h10) begin
      mismatched++;
      $display("[TB] FAIL load_ack: latency=%0d d_out=%h, want 2 10", k, d_out);
    end
    repeat (3) @(negedge clk);
    compared++;
    if (d_out !== 8'h10 || busy !== 1'b0 || ack !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL load_hold: d_out=%h busy=%b ack=%b, want 10 0 0", d_out, busy, ack);
    end
  endtask

  // Steps from 'from' to 'to'; checks direction/value each STEP cycle, freeze cycle, latency
  task automatic test_step(input logic [7:0] from, input logic [7:0] to, input string name);
    int k, n, bad;
    logic up;
    logic [7:0] exp;
    up  = (to > from);
    n   = up ? int'(to - from) : int'(from - to);
    exp = from;
    bad = 0;
    req = 1'b1; target = to; step_mode = 1'b1;
    @(posedge clk);
    for (k = 1; k <= 300; k++) begin
      @(negedge clk);
      if (k <= n) begin
        if (inc !== up || load !== 1'b0 || d_out !== exp) bad++;
        exp = up ? exp + 8'd1 : exp - 8'd1;
      end else if (k == n + 1) begin
        compared++;
        if (load !== 1'b1 || d_in !== to || d_out !== to) begin
          mismatched++;
          $display("[TB] FAIL %s_freeze: load=%b d_in=%h d_out=%h, want 1 %h %h", name, load, d_in, d_out, to, to);
        end
      end
      if (ack === 1'b1) break;
    end
    req = 1'b0;
    compared++;
    if (bad != 0) begin
      mismatched++;
      $display("[TB] FAIL %s_steps: %0d bad step cycles, want 0", name, bad);
    end
    compared++;
    if (k != n + 2) begin
      mismatched++;
      $display("[TB] FAIL %s_latency: ack at %0d, want %0d", name, k, n + 2);
    end
    repeat (3) @(negedge clk);
    compared++;
    if (d_out !== to) begin
      mismatched++;
      $display("[TB] FAIL %s_hold: d_out=%h, want %h", name, d_out, to);
    end
  endtask

  task automatic test_equal_target();
    int k;
    req = 1'b1; target = 8'h12; step_mode = 1'b1;
    @(posedge clk);
    for (k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) begin
        target = 8'h99;
        compared++;
        if (load !== 1'b1 || d_in !== 8'h12 || inc !== 1'b0) begin
          mismatched++;
          $display("[TB] FAIL equal_load: load=%b d_in=%h inc=%b, want 1 12 0", load, d_in, inc);
        end
      end
      if (ack === 1'b1) break;
    end
    req = 1'b0;
    compared++;
    if (k != 2 || d_out !== 8'h12) begin
      mismatched++;
      $display("[TB] FAIL equal_ack: latency=%0d d_out=%h, want 2 12", k, d_out);
    end
    repeat (2) @(negedge clk);
    compared++;
    if (d_out !== 8'h12 || d_in !== 8'h12) begin
      mismatched++;
      $display("[TB] FAIL equal_target_ignored: d_out=%h d_in=%h, want 12 12", d_out, d_in);
    end
  endtask

  task automatic test_reset_mid_op();
    req = 1'b1; target = 8'h30; step_mode = 1'b1;
    @(posedge clk);
    repeat (3) @(negedge clk);
    req = 1'b0;
    reset_n = 1'b0;
    #1;
    compared++;
    if (busy !== 1'b0 || load !== 1'b1 || d_in !== 8'h14 || d_out !== 8'h14) begin
      mismatched++;
      $display("[TB] FAIL mid_reset: busy=%b load=%b d_in=%h d_out=%h, want 0 1 14 14", busy, load, d_in, d_out);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    compared++;
    if (d_out !== 8'h14 || ack !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL mid_reset_park: d_out=%h ack=%b, want 14 0", d_out, ack);
    end
  endtask

`ifdef CNTR8_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    int k;
    stuck = 1'b1;
    req = 1'b1; target = 8'h40; step_mode = 1'b1;
    @(posedge clk);
    for (k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 8) begin
        compared++;
        if (load !== 1'b1 || d_in !== 8'h14) begin
          mismatched++;
          $display("[TB] FAIL timeout_freeze: load=%b d_in=%h, want 1 14", load, d_in);
        end
      end
      if (ack === 1'b1) break;
    end
    req = 1'b0;
    stuck = 1'b0;
    compared++;
    if (k != 9 || err !== 1'b1 || d_out !== 8'h14) begin
      mismatched++;
      $display("[TB] FAIL timeout_ack: at=%0d err=%b d_out=%h, want 9 1 14", k, err, d_out);
    end
    repeat (2) @(negedge clk);
    compared++;
    if (err !== 1'b1 || d_out !== 8'h14) begin
      mismatched++;
      $display("[TB] FAIL timeout_sticky: err=%b d_out=%h, want 1 14", err, d_out);
    end
    req = 1'b1; target = 8'h20; step_mode = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    compared++;
    if (err !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL timeout_clear: err=%b, want 0", err);
    end
    repeat (3) @(negedge clk);
    compared++;
    if (d_out !== 8'h20) begin
      mismatched++;
      $display("[TB] FAIL timeout_next_load: d_out=%h, want 20", d_out);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_load();
    test_step(8'h10, 8'h15, "step_up");
    test_step(8'h15, 8'h12, "step_down");
    test_equal_target();
    test_reset_mid_op();
`ifdef CNTR8_SEQ_TIMEOUT_EN
    test_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/cntr8_seq.md
# cntr8_seq

Command sequencer that drives the `cntr8` up/down counter. It accepts a target value over a req/ack handshake and moves the counter to that value, either by a single parallel load or by stepping one count per cycle. Between requests it parks the counter at its current value. It sits between host control logic and `cntr8`, owning `inc`, `load` and `d_in`, and observing `d_out`.

## Interface
Parameters:
- `TIMEOUT_CYC`, 300: maximum cycles allowed in STEP before abort. Used only with `CNTR8_SEQ_TIMEOUT_EN`.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req`  in  1  host request; held until `ack`.
- `target`  in  8  requested counter value; sampled when a request is accepted.
- `step_mode`  in  1  1 = approach by stepping, 0 = direct load; sampled with `target`.
- `ack`  out  1  one-cycle pulse on request completion.
- `busy`  out  1  high from acceptance until `ack`.
- `err`  out  1  sticky timeout flag; cleared on the next accepted request.
- `inc`  out  1  to counter: 1 = count up, 0 = count down (when `load` = 0).
- `load`  out  1  to counter: parallel load of `d_in`.
- `d_in`  out  8  to counter: load data.
- `d_out`  in  8  from counter: registered count value.

## Operation
Counter contract:
- `load` = 1: counter takes `d_in` at the next edge.
- Otherwise the counter moves ±1 per cycle per `inc`, wrapping modulo 256.
- The counter has no hold state, so the sequencer must assert `load` whenever the value must stay.

FSM states (encoding in package): IDLE, LOAD, STEP, DONE.
- **IDLE (park).** Drives `load` = 1, `d_in` = `d_out`, `inc` = 0. This is combinational feedback from the registered `d_out`; it is not a loop.
  - `req` = 1: latch `target` into `tgt_q` and `step_mode` into `mode_q`, clear `err`, set `busy`.
  - Then go to LOAD if `mode_q` = 0 or `d_out` == `target`; otherwise go to STEP.
- **LOAD.** Drives `load` = 1, `d_in` = `tgt_q`. Next state DONE.
- **STEP.** Drives `d_in` = `tgt_q`.
  - `inc` = (`tgt_q` > `d_out`), unsigned compare. Stepping never relies on wrap-around.
  - `load` = (`d_out` == `tgt_q`), a Mealy output. On the match cycle the counter reloads `tgt_q`, which freezes it. Next state DONE.
- **DONE.** Drives park outputs as in IDLE, pulses `ack` = 1, clears `busy`. Next state IDLE.

Other rules:
- `req` is ignored outside IDLE.
- `req` still high in the IDLE cycle after DONE starts a new request; the host must drop `req` on `ack`.
- Reset mid-operation returns the FSM to IDLE at once; the counter is parked at whatever value it holds.
- `tgt_q` changes only on acceptance. Changing `target` while `busy` has no effect.

## Timing
- Reset values:
  - state = IDLE.
  - `ack` = 0, `busy` = 0, `err` = 0.
  - `load` = 1, `inc` = 0, `d_in` = `d_out` (park).
- Load mode: accept at edge N, load at edge N+1, `ack` high during cycle N+2. Latency is 2 cycles from acceptance.
- Step mode: latency is |`tgt_q` − `d_out`| + 2 cycles.
  - Counter equals `tgt_q` at edge N+|Δ|.
  - Freeze load at edge N+|Δ|+1.
  - `ack` follows.
- Target equal to the current count in step mode takes the LOAD path, with the same latency as load mode.
- `d_out` == 0 with target 255 in step mode: 255 up-steps, no wrap.

## Configuration
- `CNTR8_SEQ_TIMEOUT_EN` defined:
  - A cycle counter runs while in STEP.
  - Reaching `TIMEOUT_CYC` forces `load` = 1, `d_in` = `d_out` (freeze), sets `err`, and goes to DONE; `ack` is still pulsed.
- Undefined: no counter and `err` is tied to 0. STEP exits only on match.

## Structure
- `cntr8_pkg`:
  - State typedef/localparams: IDLE = 2'd0, LOAD = 2'd1, STEP = 2'd2, DONE = 2'd3.
  - Counter width constant `CNTR_W` = 8.
- Sub-module `cntr8_seq_tmr`: clear/enable/expire timeout counter, instantiated only under `CNTR8_SEQ_TIMEOUT_EN`.
- Top-level FSM and output decode stay in `cntr8_seq`.

## Test plan
- Reset with the bench counter model at 0 → `load` = 1, `d_in` = 8'h00, `busy` = 0; `d_out` holds 0 for 20 cycles.
- `req`, `target` = 8'h10, `step_mode` = 0 → `load` = 1 with `d_in` = 8'h10 one cycle after accept; `d_out` = 8'h10; `ack` two cycles after accept; value holds afterward.
- From 8'h10, `req` with `target` = 8'h15, `step_mode` = 1 → `inc` = 1 for 5 cycles; `d_out` 11..15; freeze load; `ack` at accept+7; `d_out` stays 8'h15.
- From 8'h15, step to 8'h12 → `inc` = 0, `d_out` 14, 13, 12, then freeze; `ack` at accept+5.
- Step to a target equal to the current value (8'h12) → LOAD path, `ack` at accept+2; `target` changed while `busy` → ignored.
- With `CNTR8_SEQ_TIMEOUT_EN` and `TIMEOUT_CYC` = 8, the counter model stuck (ignores `inc`), step target 8'h40 → `err` = 1, `ack` after 8 STEP cycles, then park; the next request clears `err`.
